// File: rtl/tm1638_responder.sv
// ---------------------------------------------------------------------------
// tm1638_responder
//
// Device-side model of the TM1638 LED&KEY serial link. It sits opposite a
// board-level controller that drives tm_clk/tm_stb/tm_dio.
//
// The responder does the following:
//   - decodes data, address and display-control commands
//   - emits one-cycle display-RAM write strobes
//   - holds the display enable and brightness
//   - shifts key-scan bytes back out on read commands
//
// Optional feature macro: TM1638_RESP_ERR_EN
//   defined     -> o_frame_err is a sticky framing-error flag
//   not defined -> o_frame_err is tied to 0 and no error logic exists
//
// Parameters
//   SYNC_STAGES  synchronizer depth on tm_clk/tm_stb/tm_dio (>= 2)
//   KEY_BYTES    key-scan bytes returned per read command (1..4)
//
// Ports
//   i_clk        system clock (>= 8x tm_clk, each tm_clk phase >= 4 i_clk)
//   rst_n        asynchronous active-low reset
//   i_tm_clk     serial clock from controller, idle high
//   i_tm_stb     strobe, active low, frames one command plus payload
//   i_tm_dio     serial data pin value
//   o_tm_dio     serial data out during key read
//   o_tm_dio_oe  drive enable for o_tm_dio (tristate lives at top level)
//   i_keys       key-scan bytes, byte n = i_keys[8n+7:8n], byte 0 first
//   o_ram_we     one-cycle display-RAM write strobe
//   o_ram_addr   display-RAM write address
//   o_ram_data   display-RAM write data
//   o_disp_on    display enable from last display-control command
//   o_bright     brightness from last display-control command
//   o_frame_err  sticky framing error (only with TM1638_RESP_ERR_EN)
// ---------------------------------------------------------------------------
module tm1638_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int KEY_BYTES   = 4
) (
  input  logic        i_clk,
  input  logic        rst_n,
  input  logic        i_tm_clk,
  input  logic        i_tm_stb,
  input  logic        i_tm_dio,
  output logic        o_tm_dio,
  output logic        o_tm_dio_oe,
  input  logic [31:0] i_keys,
  output logic        o_ram_we,
  output logic [3:0]  o_ram_addr,
  output logic [7:0]  o_ram_data,
  output logic        o_disp_on,
  output logic [2:0]  o_bright,
  output logic        o_frame_err
);

  localparam int         NBITS    = 8 * KEY_BYTES;
  localparam logic [5:0] LAST_IDX = 6'(NBITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_WDATA,
    S_RDATA,
    S_IGNORE
  } state_t;

  // Synchronizers reset to 1 so the idle-high bus does not look like an edge
  logic [SYNC_STAGES-1:0] r_clkSync, r_stbSync, r_dioSync;
  logic                   r_clkPrev, r_stbPrev;

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clkSync <= '1;
      r_stbSync <= '1;
      r_dioSync <= '1;
      r_clkPrev <= 1'b1;
      r_stbPrev <= 1'b1;
    end else begin
      r_clkSync <= {r_clkSync[SYNC_STAGES-2:0], i_tm_clk};
      r_stbSync <= {r_stbSync[SYNC_STAGES-2:0], i_tm_stb};
      r_dioSync <= {r_dioSync[SYNC_STAGES-2:0], i_tm_dio};
      r_clkPrev <= r_clkSync[SYNC_STAGES-1];
      r_stbPrev <= r_stbSync[SYNC_STAGES-1];
    end
  end

  logic w_clk, w_stb, w_dio;
  logic w_clkRise, w_stbFall, w_stbRise;

  assign w_clk     = r_clkSync[SYNC_STAGES-1];
  assign w_stb     = r_stbSync[SYNC_STAGES-1];
  assign w_dio     = r_dioSync[SYNC_STAGES-1];
  assign w_clkRise = w_clk & ~r_clkPrev;
  assign w_stbFall = ~w_stb & r_stbPrev;
  assign w_stbRise = w_stb & ~r_stbPrev;

  state_t             r_state, w_stateNext;
  logic [2:0]         r_bitCnt, w_bitCntNext;
  logic [7:0]         r_shift, w_shiftNext;
  logic [3:0]         r_addr, w_addrNext;
  logic               r_fixed, w_fixedNext;
  logic [NBITS-1:0]   r_snap, w_snapNext;
  logic [5:0]         r_rdIdx, w_rdIdxNext;
  logic               r_dio, w_dioNext;
  logic               r_oe, w_oeNext;
  logic               r_ramWe, w_ramWeNext;
  logic [3:0]         r_ramAddr, w_ramAddrNext;
  logic [7:0]         r_ramData, w_ramDataNext;
  logic               r_dispOn, w_dispOnNext;
  logic [2:0]         r_bright, w_brightNext;
  logic [7:0]         w_byte;

`ifdef TM1638_RESP_ERR_EN
  logic               r_frameErr;
  logic               w_errSet;
`endif

  // Byte arrives LSB first, so the newest bit enters at the top
  assign w_byte = {w_dio, r_shift[7:1]};

  // Next-state and datapath decode. A strobe edge overrides any clock edge
  // in the same cycle, so a byte that completes together with stb rising
  // is dropped.
  always_comb begin
    w_stateNext   = r_state;
    w_bitCntNext  = r_bitCnt;
    w_shiftNext   = r_shift;
    w_addrNext    = r_addr;
    w_fixedNext   = r_fixed;
    w_snapNext    = r_snap;
    w_rdIdxNext   = r_rdIdx;
    w_dioNext     = r_dio;
    w_oeNext      = r_oe;
    w_ramWeNext   = 1'b0;
    w_ramAddrNext = r_ramAddr;
    w_ramDataNext = r_ramData;
    w_dispOnNext  = r_dispOn;
    w_brightNext  = r_bright;
`ifdef TM1638_RESP_ERR_EN
    w_errSet      = 1'b0;
`endif
    if (w_stbFall) begin
      w_stateNext  = S_CMD;
      w_bitCntNext = 3'd0;
      w_shiftNext  = 8'h00;
      w_oeNext     = 1'b0;
      w_dioNext    = 1'b1;
    end else if (w_stbRise) begin
      w_stateNext  = S_IDLE;
      w_bitCntNext = 3'd0;
      w_shiftNext  = 8'h00;
      w_oeNext     = 1'b0;
      w_dioNext    = 1'b1;
`ifdef TM1638_RESP_ERR_EN
      w_errSet     = (r_bitCnt != 3'd0);
`endif
    end else if (w_clkRise && !w_stb) begin
      unique case (r_state)
        S_CMD, S_WDATA: begin
          w_shiftNext  = w_byte;
          w_bitCntNext = r_bitCnt + 3'd1;
          if (r_bitCnt == 3'd7) begin
            w_shiftNext = 8'h00;
            if (r_state == S_WDATA) begin
              w_ramWeNext   = 1'b1;
              w_ramAddrNext = r_addr;
              w_ramDataNext = w_byte;
              if (!r_fixed) begin
                w_addrNext = r_addr + 4'd1;
              end
            end else begin
              unique case (w_byte[7:6])
                2'b01: begin
                  w_fixedNext = w_byte[2];
                  if (w_byte[1]) begin
                    w_snapNext  = i_keys[NBITS-1:0];
                    w_rdIdxNext = 6'd0;
                    w_oeNext    = 1'b1;
                    w_dioNext   = i_keys[0];
                    w_stateNext = S_RDATA;
                  end else begin
                    w_stateNext = S_IGNORE;
                  end
                end
                2'b10: begin
                  w_dispOnNext = w_byte[3];
                  w_brightNext = w_byte[2:0];
                  w_stateNext  = S_IGNORE;
                end
                2'b11: begin
                  w_addrNext  = w_byte[3:0];
                  w_stateNext = S_WDATA;
                end
                default: begin
                  w_stateNext = S_IGNORE;
`ifdef TM1638_RESP_ERR_EN
                  w_errSet    = 1'b1;
`endif
                end
              endcase
            end
          end
        end
        // Controller has just sampled the current bit; present the next one
        S_RDATA: begin
          if (r_rdIdx == LAST_IDX) begin
            w_oeNext    = 1'b0;
            w_dioNext   = 1'b1;
            w_stateNext = S_IGNORE;
          end else begin
            w_rdIdxNext = r_rdIdx + 6'd1;
            w_snapNext  = {1'b1, r_snap[NBITS-1:1]};
            w_dioNext   = r_snap[1];
          end
        end
        default: begin
        end
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_bitCnt  <= 3'd0;
      r_shift   <= 8'h00;
      r_addr    <= 4'd0;
      r_fixed   <= 1'b0;
      r_snap    <= '0;
      r_rdIdx   <= 6'd0;
      r_dio     <= 1'b1;
      r_oe      <= 1'b0;
      r_ramWe   <= 1'b0;
      r_ramAddr <= 4'd0;
      r_ramData <= 8'h00;
      r_dispOn  <= 1'b0;
      r_bright  <= 3'd0;
    end else begin
      r_state   <= w_stateNext;
      r_bitCnt  <= w_bitCntNext;
      r_shift   <= w_shiftNext;
      r_addr    <= w_addrNext;
      r_fixed   <= w_fixedNext;
      r_snap    <= w_snapNext;
      r_rdIdx   <= w_rdIdxNext;
      r_dio     <= w_dioNext;
      r_oe      <= w_oeNext;
      r_ramWe   <= w_ramWeNext;
      r_ramAddr <= w_ramAddrNext;
      r_ramData <= w_ramDataNext;
      r_dispOn  <= w_dispOnNext;
      r_bright  <= w_brightNext;
    end
  end

`ifdef TM1638_RESP_ERR_EN
  // Sticky until reset
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frameErr <= 1'b0;
    end else if (w_errSet) begin
      r_frameErr <= 1'b1;
    end
  end

  assign o_frame_err = r_frameErr;
`else
  assign o_frame_err = 1'b0;
`endif

  assign o_tm_dio    = r_dio;
  assign o_tm_dio_oe = r_oe;
  assign o_ram_we    = r_ramWe;
  assign o_ram_addr  = r_ramAddr;
  assign o_ram_data  = r_ramData;
  assign o_disp_on   = r_dispOn;
  assign o_bright    = r_bright;

endmodule

// File: tb/tb_tm1638_responder.sv
// ---------------------------------------------------------------------------
// tb_tm1638_responder
//
// Self-checking bench for tm1638_responder. The bench acts as the serial
// controller. Expected RAM writes, display state, key bytes and error flag
// all come from a small frame-level model held in the bench.
// ---------------------------------------------------------------------------
module tb_tm1638_responder;

  localparam int PH      = 6;
  localparam int LATENCY = 3;
`ifdef TM1638_RESP_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        rst_n;
  logic        tmClk, tmStb, tmDio;
  logic        o_tm_dio, o_tm_dio_oe;
  logic [31:0] keys;
  logic        o_ram_we;
  logic [3:0]  o_ram_addr;
  logic [7:0]  o_ram_data;
  logic        o_disp_on;
  logic [2:0]  o_bright;
  logic        o_frame_err;

  tm1638_responder dut (
    .i_clk       (i_clk),
    .rst_n       (rst_n),
    .i_tm_clk    (tmClk),
    .i_tm_stb    (tmStb),
    .i_tm_dio    (tmDio),
    .o_tm_dio    (o_tm_dio),
    .o_tm_dio_oe (o_tm_dio_oe),
    .i_keys      (keys),
    .o_ram_we    (o_ram_we),
    .o_ram_addr  (o_ram_addr),
    .o_ram_data  (o_ram_data),
    .o_disp_on   (o_disp_on),
    .o_bright    (o_bright),
    .o_frame_err (o_frame_err)
  );

  always #5 i_clk = ~i_clk;

  int cycleCnt = 0;
  always @(posedge i_clk) cycleCnt <= cycleCnt + 1;

  int testsRun    = 0;
  int testsFailed = 0;
  int lastRise    = 0;

  // Every cycle the write strobe is seen high becomes its own entry
  int         actCyc[$];
  logic [3:0] actAddr[$];
  logic [7:0] actData[$];
  always @(negedge i_clk) begin
    if (rst_n && o_ram_we) begin
      actCyc.push_back(cycleCnt);
      actAddr.push_back(o_ram_addr);
      actData.push_back(o_ram_data);
    end
  end

  logic [3:0] expAddr[$];
  logic [7:0] expData[$];
  logic [7:0] frameQ[$];
  int         byteEndCyc[$];
  bit         mFixed, mDisp, mErr;
  bit [2:0]   mBright;

  task automatic tick(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sendBits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      tmClk = 1'b0;
      tmDio = b[i];
      tick(PH);
      tmClk = 1'b1;
      lastRise = cycleCnt;
      tick(PH);
    end
  endtask

  // Frame-level model: what the controller expects a whole frame to do
  task automatic modelFrame();
    logic [7:0] cmd;
    cmd = frameQ[0];
    case (cmd[7:6])
      2'b01: mFixed = cmd[2];
      2'b10: begin
        mDisp   = cmd[3];
        mBright = cmd[2:0];
      end
      2'b11: begin
        for (int k = 1; k < frameQ.size(); k++) begin
          expAddr.push_back(mFixed ? cmd[3:0] : 4'((int'(cmd[3:0]) + k - 1) % 16));
          expData.push_back(frameQ[k]);
        end
      end
      default: mErr = ERR_EN;
    endcase
  endtask

  task automatic applyStimulus();
    modelFrame();
    byteEndCyc.delete();
    tmStb = 1'b0;
    tick(PH);
    for (int i = 0; i < frameQ.size(); i++) begin
      sendBits(frameQ[i], 8);
      byteEndCyc.push_back(lastRise);
    end
    tmStb = 1'b1;
    tick(PH);
    frameQ.delete();
  endtask

  task automatic compareWrites(input string tag);
    int n;
    checkOutput({tag, "_cnt"}, 32'(actAddr.size()), 32'(expAddr.size()));
    n = (actAddr.size() < expAddr.size()) ? actAddr.size() : expAddr.size();
    for (int i = 0; i < n; i++) begin
      checkOutput({tag, "_addr"}, 32'(actAddr[i]), 32'(expAddr[i]));
      checkOutput({tag, "_data"}, 32'(actData[i]), 32'(expData[i]));
    end
    actCyc.delete();
    actAddr.delete();
    actData.delete();
    expAddr.delete();
    expData.delete();
  endtask

  // Read command 0x42 followed by clocking out every key byte
  task automatic readFrame(input logic [31:0] k, input bit changeMid);
    logic [7:0] got;
    bit         oeAll;
    keys   = k;
    mFixed = 1'b0;
    tmStb  = 1'b0;
    tick(PH);
    sendBits(8'h42, 8);
    for (int j = 0; j < 4; j++) begin
      oeAll = 1'b1;
      for (int i = 0; i < 8; i++) begin
        tmClk = 1'b0;
        tick(PH);
        got[i] = o_tm_dio;
        oeAll  = oeAll & o_tm_dio_oe;
        tmClk  = 1'b1;
        tick(PH);
      end
      checkOutput("rd_byte", 32'(got), 32'(k[8*j +: 8]));
      checkOutput("rd_oe", 32'(oeAll), 32'(1));
      if (changeMid && j == 0) keys = $urandom;
    end
    checkOutput("rd_oe_end", 32'(o_tm_dio_oe), 32'(0));
    checkOutput("rd_dio_end", 32'(o_tm_dio), 32'(1));
    tmStb = 1'b1;
    tick(PH);
  endtask

  task automatic checkDisplay(input string tag);
    checkOutput({tag, "_disp"}, 32'(o_disp_on), 32'(mDisp));
    checkOutput({tag, "_bright"}, 32'(o_bright), 32'(mBright));
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_we"}, 32'(o_ram_we), 32'(0));
    checkOutput({tag, "_addr"}, 32'(o_ram_addr), 32'(0));
    checkOutput({tag, "_data"}, 32'(o_ram_data), 32'(0));
    checkOutput({tag, "_disp"}, 32'(o_disp_on), 32'(0));
    checkOutput({tag, "_bright"}, 32'(o_bright), 32'(0));
    checkOutput({tag, "_dio"}, 32'(o_tm_dio), 32'(1));
    checkOutput({tag, "_oe"}, 32'(o_tm_dio_oe), 32'(0));
    checkOutput({tag, "_err"}, 32'(o_frame_err), 32'(0));
  endtask

  task automatic resetModel();
    mFixed  = 1'b0;
    mDisp   = 1'b0;
    mBright = 3'd0;
    mErr    = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    int         op, n;

    // Reset state
    rst_n = 1'b0;
    tmClk = 1'b1;
    tmStb = 1'b1;
    tmDio = 1'b1;
    keys  = 32'h0;
    resetModel();
    tick(3);
    checkResetOutputs("reset");
    rst_n = 1'b1;
    tick(3);

    // Auto-increment writes and strobe latency
    frameQ = '{8'h40};
    applyStimulus();
    frameQ = '{8'hC0, 8'h3F, 8'h06};
    applyStimulus();
    if (actCyc.size() > 0)
      checkOutput("we_latency", 32'(actCyc[0] - byteEndCyc[1]), 32'(LATENCY));
    else
      checkOutput("we_latency_seen", 32'(0), 32'(1));
    compareWrites("incr");

    // Fixed-address writes
    frameQ = '{8'h44};
    applyStimulus();
    frameQ = '{8'hC5, 8'hAA, 8'hBB};
    applyStimulus();
    compareWrites("fixed");

    // Address wrap from 0xF to 0x0
    frameQ = '{8'h40};
    applyStimulus();
    frameQ = '{8'hCF, 8'h11, 8'h22};
    applyStimulus();
    compareWrites("wrap");

    // Display control
    frameQ = '{8'h8F};
    applyStimulus();
    checkDisplay("disp_on");
    frameQ = '{8'h80};
    applyStimulus();
    checkDisplay("disp_off");
    compareWrites("disp_nowr");

    // Key read, with the key inputs changed after the first byte
    readFrame(32'h04030201, 1'b1);

    // Randomized frames against the model
    for (int it = 0; it < 16; it++) begin
      op = $urandom_range(0, 2);
      if (op == 0) begin
        if ($urandom_range(0, 1) == 1) begin
          frameQ = '{8'h40 | 8'($urandom_range(0, 1) << 2)};
          applyStimulus();
        end
        b = 8'hC0 | 8'($urandom_range(0, 15));
        frameQ = '{b};
        n = $urandom_range(1, 4);
        for (int k = 0; k < n; k++) frameQ.push_back(8'($urandom));
        applyStimulus();
        compareWrites("rnd_wr");
      end else if (op == 1) begin
        frameQ = '{8'h80 | 8'($urandom_range(0, 15))};
        applyStimulus();
        checkDisplay("rnd_disp");
      end else begin
        readFrame($urandom, 1'b1);
      end
    end

    // Invalid command, then reset clears the sticky flag
    checkOutput("err_pre", 32'(o_frame_err), 32'(0));
    frameQ = '{8'h00};
    applyStimulus();
    checkOutput("err_invalid", 32'(o_frame_err), 32'(mErr));
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    resetModel();
    tick(2);
    checkOutput("err_cleared", 32'(o_frame_err), 32'(0));

    // Strobe rises after 5 data bits: no write, framing error
    tmStb = 1'b0;
    tick(PH);
    sendBits(8'hC0, 8);
    sendBits(8'h15, 5);
    tmStb = 1'b1;
    mErr  = ERR_EN;
    tick(PH);
    compareWrites("partial");
    checkOutput("err_partial", 32'(o_frame_err), 32'(mErr));

    // Strobe and 8th clock rise together: strobe wins, byte dropped
    tmStb = 1'b0;
    tick(PH);
    sendBits(8'hC3, 8);
    sendBits(8'h55, 7);
    tmClk = 1'b0;
    tmDio = 1'b0;
    tick(PH);
    tmClk = 1'b1;
    tmStb = 1'b1;
    tick(PH);
    tick(PH);
    compareWrites("stb_wins");

    // A normal frame still works afterwards
    frameQ = '{8'hC2, 8'h99};
    applyStimulus();
    compareWrites("recover");

    // Asynchronous reset in the middle of a key read
    frameQ = '{8'h8B};
    applyStimulus();
    keys  = $urandom;
    tmStb = 1'b0;
    tick(PH);
    sendBits(8'h42, 8);
    for (int i = 0; i < 2; i++) begin
      tmClk = 1'b0;
      tick(PH);
      tmClk = 1'b1;
      tick(PH);
    end
    checkOutput("mid_rd_oe", 32'(o_tm_dio_oe), 32'(1));
    rst_n = 1'b0;
    #1;
    checkResetOutputs("async_rst");
    resetModel();
    tmStb = 1'b1;
    tick(PH);
    rst_n = 1'b1;
    tick(PH);
    frameQ = '{8'h8A};
    applyStimulus();
    checkDisplay("post_rst");
    compareWrites("post_rst");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
